mii_tx_encoder: RTL and testbench
=================================

# mii_tx_encoder

Transmit-side 64-bit MII encoder downstream of the MAC frame generator. It takes complete frame words (preamble/SFD, header, payload, FCS) over a valid/ready stream and drives the 64-bit data / 8-bit control MII lanes. It inserts Start, Terminate and Idle control characters, enforces the inter-packet gap, and flags underrun and oversize frames with Error characters.

## Interface
- `IPG_BYTES`, 12 — minimum idle bytes between the /T/ character and the next /S/ character.
- `MAX_FRAME_BYTES`, 1530 — maximum accepted bytes per frame, preamble included; a frame longer than this is truncated with an error.
- `clk` in 1 — the single clock.
- `i_rst` in 1 — reset, asynchronous, active-high.
- `i_valid` in 1 — input word valid.
- `i_data` in 64 — frame bytes; byte n sits in bits [8n+7:8n]; lane 0 goes on the wire first; the first word of a frame is preamble/SFD.
- `i_last` in 1 — marks the last word of the frame.
- `i_keep` in 8 — valid-byte mask, meaningful only when `i_last` is high; contiguous from bit 0; nonzero.
- `o_ready` in/out: out 1 — the block accepts a word when `i_valid && o_ready`.
- `o_txd` out 64 — MII data lanes.
- `o_txc` out 8 — MII control flags; one bit per lane, 1 = control character.
- `o_underrun` out 1 — one-cycle pulse when `i_valid` drops mid-frame.
- `o_oversize` out 1 — one-cycle pulse when a frame exceeds `MAX_FRAME_BYTES`.
- `o_frame_count` out 16 — count of good frames terminated; wraps at 0xFFFF to 0.

## Operation
**States:** IDLE, DATA, TERM, IPG, DROP.

**IDLE**
- Emits an all-Idle word.
- `o_ready` = (`idle_cnt` ≥ `IPG_BYTES`).
- On an accepted word, the output is `i_data` with lane 0 replaced by /S/ = 0xFB, and `o_txc` = 0x01.
- If `i_last` is also high, the word is handled per the DATA last-word rule; otherwise go to DATA.

**DATA**
- `o_ready` = 1. An accepted non-last word passes through with `o_txc` = 0x00.
- Last word with k = popcount(`i_keep`):
  - k < 8: lanes 0..k-1 carry data, lane k = /T/ 0xFD, lanes k+1..7 = /I/ 0x07, txc bits k..7 set. `idle_cnt` := 7-k. Go to IPG; `o_frame_count` += 1.
  - k = 8: full data word, go to TERM.
- No accepted word (underrun): emit all-/E/ 0xFE with `o_txc` = 0xFF, pulse `o_underrun`, `idle_cnt` := 0, go to IPG. The frame is not counted.

**TERM**
- `o_ready` = 0. Emit /T/ in lane 0 and /I/ in lanes 1..7, `o_txc` = 0xFF, `idle_cnt` := 7.
- `o_frame_count` += 1. Go to IPG.

**IPG**
- `o_ready` = 0. Emit all-Idle; `idle_cnt` += 8, saturating at 255.
- Go to IDLE once the next value is ≥ `IPG_BYTES`.

**Byte counting**
- `byte_cnt` (16 bit) adds k per accepted word, with k = 8 on non-last words.
- If an accepted non-last word would make `byte_cnt` exceed `MAX_FRAME_BYTES`: emit all-/E/, pulse `o_oversize`, go to DROP.

**DROP**
- `o_ready` = 1; emit all-Idle; discard words.
- On an accepted `i_last`: `idle_cnt` := 0, go to IPG.

**General rules**
- `i_keep` is ignored when `i_last` is low.
- A first word arriving with `i_last` high is treated as a frame whose /S/ replaces lane 0.

## Timing
- **Reset values:** `o_txd` = 0x0707070707070707, `o_txc` = 0xFF, `o_underrun` = 0, `o_oversize` = 0, `o_frame_count` = 0. State = IDLE, `idle_cnt` = 255, so `o_ready` = 1 right after reset.
- Reset asserted mid-frame returns to the reset values immediately; no /T/ is emitted.
- All outputs except `o_ready` are registered. Latency from an accepted input word to `o_txd` is 1 cycle.
- `o_ready` is combinational from state and `idle_cnt` only, never from `i_valid`.
- **Gap arithmetic:** the gap always ends on a word boundary. With `IPG_BYTES` = 12 and k = 4, the sequence is 3 idle bytes in the /T/ word, then 2 full Idle words (3+8 = 11 < 12, so a second word is needed; 19 ≥ 12), and /S/ appears on the following cycle at the earliest.
- Pulses `o_underrun` and `o_oversize` last exactly one cycle and align with the /E/ word.

## Structure
- **Shared package `mii_pkg`:**
  - constants `MII_IDLE` = 0x07, `MII_START` = 0xFB, `MII_TERM` = 0xFD, `MII_ERROR` = 0xFE;
  - the state enum `mii_tx_state_t`;
  - function `mii_term_word(data, keep)` returning {txd, txc} for a last word.
- One sub-module is natural: `mii_ipg_counter`, the saturating idle-byte counter with its ≥ `IPG_BYTES` compare. Everything else stays in `mii_tx_encoder`.

## Test plan
- **Back-to-back frames:** two 9-word frames, `i_valid` held high, keep = 0x0F on the last word → word 0 of each shows 0xFB/txc 0x01, last word lanes 4..7 = FD,07,07,07 with txc 0xF0, two Idle words, then the next /S/; `o_frame_count` = 2.
- **Full last word:** keep = 0xFF → one extra cycle with `o_txd` = 0x07070707070707FD, `o_txc` = 0xFF; `idle_cnt` path gives 7+8 = 15 ≥ 12, so exactly 1 Idle word follows.
- **Underrun:** drop `i_valid` on word 4 of a frame → one word of 0xFEFE…FE with txc 0xFF, `o_underrun` pulse, no /T/, `o_frame_count` unchanged.
- **Oversize:** `MAX_FRAME_BYTES` = 64, send a 12-word frame → /E/ on the word that would reach 72 bytes, `o_oversize` pulse, remaining words accepted silently, then IPG.
- **Reset mid-frame:** assert `i_rst` during DATA → same cycle `o_txd` = all 0x07, `o_txc` = 0xFF, `o_frame_count` = 0; a new frame is accepted after release with /S/ in lane 0.
- **Single-word frame:** `i_valid` with `i_last`, keep = 0x03 on the first word → lane 0 = FB, lane 1 = data, lane 2 = FD, txc = 0xFD.

Source files
------------

// File: rtl/mii_pkg.sv
// Shared MII transmit definitions: control characters, encoder states and
// the last-word (terminate) formatter.
package mii_pkg;

  localparam logic [7:0]  MII_IDLE       = 8'h07;
  localparam logic [7:0]  MII_START      = 8'hFB;
  localparam logic [7:0]  MII_TERM       = 8'hFD;
  localparam logic [7:0]  MII_ERROR      = 8'hFE;
  localparam logic [63:0] MII_IDLE_WORD  = {8{MII_IDLE}};
  localparam logic [63:0] MII_ERROR_WORD = {8{MII_ERROR}};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DATA = 3'd1,
    ST_TERM = 3'd2,
    ST_IPG  = 3'd3,
    ST_DROP = 3'd4
  } mii_tx_state_t;

  function automatic logic [3:0] mii_keep_count(input logic [7:0] keep);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'd0, keep[i]};
    end
    return cnt;
  endfunction

  // Returns {txd, txc}: k data lanes, /T/ in lane k, /I/ above; k = 8 is plain data.
  function automatic logic [71:0] mii_term_word(input logic [63:0] data,
                                                input logic [7:0]  keep);
    logic [63:0] txd;
    logic [7:0]  txc;
    logic [3:0]  k;
    logic [3:0]  lane;
    k   = mii_keep_count(keep);
    txd = data;
    txc = 8'h00;
    for (int i = 0; i < 8; i++) begin
      lane = 4'(i);
      if (lane < k) begin
        txc[i] = 1'b0;
      end else if (lane == k) begin
        txd[8*i +: 8] = MII_TERM;
        txc[i]        = 1'b1;
      end else begin
        txd[8*i +: 8] = MII_IDLE;
        txc[i]        = 1'b1;
      end
    end
    return {txd, txc};
  endfunction

endpackage

// File: rtl/mii_tx_encoder_ipg_counter.sv
// Saturating count of idle bytes sent since the last /T/ or /E/, with the
// inter-packet-gap threshold compare for the current and next count.
module mii_ipg_counter #(
  parameter int IPG_BYTES = 12
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       inc,
  output logic       gap_met,
  output logic       next_gap_met
);

  logic [7:0] cnt_r;
  logic [8:0] sum_s;
  logic [7:0] inc_val_s;

  // Add one idle word (8 bytes), clamping at 255
  always_comb begin
    sum_s = {1'b0, cnt_r} + 9'd8;
    if (sum_s > 9'd255) begin
      inc_val_s = 8'hFF;
    end else begin
      inc_val_s = sum_s[7:0];
    end
  end

  assign gap_met      = ({24'd0, cnt_r} >= 32'(IPG_BYTES));
  assign next_gap_met = ({24'd0, inc_val_s} >= 32'(IPG_BYTES));

  // Counter register; a load wins over an increment
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_r <= 8'hFF;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (inc) begin
      cnt_r <= inc_val_s;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/mii_tx_encoder.sv
// 64-bit MII transmit encoder: frames a valid/ready word stream with /S/, /T/,
// /I/ and /E/ characters and enforces the inter-packet gap.
module mii_tx_encoder
  import mii_pkg::*;
#(
  parameter int IPG_BYTES       = 12,
  parameter int MAX_FRAME_BYTES = 1530
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [63:0] i_data,
  input  logic        i_last,
  input  logic [7:0]  i_keep,
  output logic        o_ready,
  output logic [63:0] o_txd,
  output logic [7:0]  o_txc,
  output logic        o_underrun,
  output logic        o_oversize,
  output logic [15:0] o_frame_count
);

  mii_tx_state_t state_r;
  logic [15:0]   byte_cnt_r;
  logic [63:0]   txd_r;
  logic [7:0]    txc_r;
  logic          underrun_r;
  logic          oversize_r;
  logic [15:0]   frame_count_r;

  logic          ready_s;
  logic          accept_s;
  logic [3:0]    keep_cnt_s;
  logic [71:0]   term_s;
  logic [15:0]   byte_add_s;
  logic [15:0]   byte_sum_s;
  logic          too_long_s;
  logic          ipg_load_s;
  logic [7:0]    ipg_load_val_s;
  logic          ipg_inc_s;
  logic          gap_met_s;
  logic          next_gap_met_s;

  mii_ipg_counter #(.IPG_BYTES(IPG_BYTES)) u_ipg (
    .clk          (clk),
    .i_rst        (i_rst),
    .load         (ipg_load_s),
    .load_val     (ipg_load_val_s),
    .inc          (ipg_inc_s),
    .gap_met      (gap_met_s),
    .next_gap_met (next_gap_met_s)
  );

  assign accept_s   = i_valid && ready_s;
  assign keep_cnt_s = mii_keep_count(i_keep);
  assign term_s     = mii_term_word(i_data, i_keep);
  assign byte_add_s = i_last ? {12'd0, keep_cnt_s} : 16'd8;
  assign byte_sum_s = byte_cnt_r + byte_add_s;
  assign too_long_s = (byte_sum_s > 16'(MAX_FRAME_BYTES));

  // Ready depends on state and gap only, never on i_valid
  always_comb begin
    case (state_r)
      ST_IDLE: ready_s = gap_met_s;
      ST_DATA: ready_s = 1'b1;
      ST_DROP: ready_s = 1'b1;
      default: ready_s = 1'b0;
    endcase
  end

  // Idle-byte counter control: reload on /T/ or /E/ words, count in IPG
  always_comb begin
    ipg_load_s     = 1'b0;
    ipg_load_val_s = 8'd0;
    ipg_inc_s      = 1'b0;
    case (state_r)
      ST_IDLE, ST_DATA: begin
        if (accept_s && i_last && (keep_cnt_s != 4'd8)) begin
          ipg_load_s     = 1'b1;
          ipg_load_val_s = 8'd7 - {4'd0, keep_cnt_s};
        end else if ((state_r == ST_DATA) && !accept_s) begin
          ipg_load_s     = 1'b1;
          ipg_load_val_s = 8'd0;
        end else begin
          ipg_load_s     = 1'b0;
        end
      end
      ST_TERM: begin
        ipg_load_s     = 1'b1;
        ipg_load_val_s = 8'd7;
      end
      ST_IPG:  ipg_inc_s = 1'b1;
      ST_DROP: begin
        if (accept_s && i_last) begin
          ipg_load_s = 1'b1;
        end else begin
          ipg_load_s = 1'b0;
        end
      end
      default: ipg_load_s = 1'b0;
    endcase
  end

  // Framing FSM with registered lane outputs
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_r       <= ST_IDLE;
      byte_cnt_r    <= 16'd0;
      txd_r         <= MII_IDLE_WORD;
      txc_r         <= 8'hFF;
      underrun_r    <= 1'b0;
      oversize_r    <= 1'b0;
      frame_count_r <= 16'd0;
    end else begin
      underrun_r <= 1'b0;
      oversize_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            byte_cnt_r <= byte_add_s;
            if (i_last && (keep_cnt_s != 4'd8)) begin
              txd_r         <= {term_s[71:16], MII_START};
              txc_r         <= term_s[7:0] | 8'h01;
              frame_count_r <= frame_count_r + 16'd1;
              state_r       <= ST_IPG;
            end else begin
              txd_r   <= {i_data[63:8], MII_START};
              txc_r   <= 8'h01;
              state_r <= i_last ? ST_TERM : ST_DATA;
            end
          end else begin
            txd_r <= MII_IDLE_WORD;
            txc_r <= 8'hFF;
          end
        end
        ST_DATA: begin
          if (!accept_s) begin
            txd_r      <= MII_ERROR_WORD;
            txc_r      <= 8'hFF;
            underrun_r <= 1'b1;
            state_r    <= ST_IPG;
          end else if (!i_last && too_long_s) begin
            txd_r      <= MII_ERROR_WORD;
            txc_r      <= 8'hFF;
            oversize_r <= 1'b1;
            state_r    <= ST_DROP;
          end else if (!i_last || (keep_cnt_s == 4'd8)) begin
            byte_cnt_r <= byte_sum_s;
            txd_r      <= i_data;
            txc_r      <= 8'h00;
            state_r    <= i_last ? ST_TERM : ST_DATA;
          end else begin
            byte_cnt_r    <= byte_sum_s;
            txd_r         <= term_s[71:8];
            txc_r         <= term_s[7:0];
            frame_count_r <= frame_count_r + 16'd1;
            state_r       <= ST_IPG;
          end
        end
        ST_TERM: begin
          txd_r         <= {{7{MII_IDLE}}, MII_TERM};
          txc_r         <= 8'hFF;
          frame_count_r <= frame_count_r + 16'd1;
          state_r       <= ST_IPG;
        end
        ST_IPG: begin
          txd_r   <= MII_IDLE_WORD;
          txc_r   <= 8'hFF;
          state_r <= next_gap_met_s ? ST_IDLE : ST_IPG;
        end
        ST_DROP: begin
          txd_r   <= MII_IDLE_WORD;
          txc_r   <= 8'hFF;
          state_r <= (accept_s && i_last) ? ST_IPG : ST_DROP;
        end
        default: begin
          txd_r   <= MII_IDLE_WORD;
          txc_r   <= 8'hFF;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ready       = ready_s;
  assign o_txd         = txd_r;
  assign o_txc         = txc_r;
  assign o_underrun    = underrun_r;
  assign o_oversize    = oversize_r;
  assign o_frame_count = frame_count_r;

endmodule

// File: tb/tb_mii_tx_encoder.sv
// Scoreboard bench for mii_tx_encoder: frames are expanded into an expected
// MII byte stream, chopped into words, and compared against a token monitor.
`timescale 1ns/1ps
module tb_mii_tx_encoder;

  localparam int          IPG   = 12;
  localparam int          MAXB  = 64;
  localparam logic [63:0] IDLEW = 64'h0707070707070707;

  logic        clk = 1'b0;
  logic        i_rst, i_valid, i_last;
  logic [63:0] i_data;
  logic [7:0]  i_keep;
  logic        o_ready;
  logic [63:0] o_txd;
  logic [7:0]  o_txc;
  logic        o_underrun, o_oversize;
  logic [15:0] o_frame_count;

  mii_tx_encoder #(.IPG_BYTES(IPG), .MAX_FRAME_BYTES(MAXB)) dut (
    .clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
    .i_last(i_last), .i_keep(i_keep), .o_ready(o_ready), .o_txd(o_txd),
    .o_txc(o_txc), .o_underrun(o_underrun), .o_oversize(o_oversize),
    .o_frame_count(o_frame_count)
  );

  always #5 clk = ~clk;

  // A token is either one non-idle output word or a run of all-idle words.
  typedef struct {
    bit          is_gap;
    int          gap_words;
    logic [63:0] txd;
    logic [7:0]  txc;
    logic        ur;
    logic        ov;
    logic [15:0] cnt;
  } tok_t;

  tok_t       exp_q[$];
  logic [7:0] sb_q[$];
  bit         sc_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  int         model_count = 0;
  int         pending_gap = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b, input bit c);
    sb_q.push_back(b);
    sc_q.push_back(c);
  endtask

  // Cut the byte stream into 8-byte words; a word carrying /T/ completes a good frame
  task automatic push_stream();
    tok_t t;
    bit   has_t;
    while (sb_q.size() >= 8) begin
      has_t = 1'b0;
      t.is_gap = 1'b0; t.gap_words = 0; t.ur = 1'b0; t.ov = 1'b0;
      for (int j = 0; j < 8; j++) begin
        logic [7:0] b;
        bit         c;
        b = sb_q.pop_front();
        c = sc_q.pop_front();
        t.txd[8*j +: 8] = b;
        t.txc[j]        = c;
        if (c && b == 8'hFD) has_t = 1'b1;
      end
      if (has_t) model_count++;
      t.cnt = 16'(model_count);
      exp_q.push_back(t);
    end
  endtask

  task automatic push_error(input bit ur, input bit ov);
    tok_t t;
    t.is_gap = 1'b0; t.gap_words = 0;
    t.txd = 64'hFEFEFEFEFEFEFEFE; t.txc = 8'hFF;
    t.ur = ur; t.ov = ov; t.cnt = 16'(model_count);
    exp_q.push_back(t);
  endtask

  // Whole idle words needed after 'tail' idle bytes to reach the gap
  function automatic int gap_words(input int tail);
    int t = tail;
    int w = 0;
    while (t < IPG) begin
      t += 8;
      w++;
    end
    return w;
  endfunction

  task automatic send_word(input logic [63:0] d, input logic l, input logic [7:0] k);
    bit acc;
    int n = 0;
    i_valid = 1'b1; i_data = d; i_last = l; i_keep = k;
    forever begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 100) begin
        checks++; errors++;
        $display("FAIL ready_timeout: got no ready in %0d cycles, expected ready", n);
        break;
      end
    end
  endtask

  // under_m > 0: send under_m non-last words, then drop valid for one cycle
  task automatic send_frame(input int n, input int k, input int under_m);
    logic [63:0] words [16];
    logic [7:0]  keepm;
    int          nw;
    int          tail;
    nw    = (under_m > 0) ? under_m : n;
    keepm = 8'((1 << k) - 1);
    for (int i = 0; i < nw; i++) words[i] = {$urandom, $urandom};
    if (pending_gap > 0) begin
      tok_t g;
      g.is_gap = 1'b1; g.gap_words = pending_gap;
      g.txd = IDLEW; g.txc = 8'hFF; g.ur = 1'b0; g.ov = 1'b0; g.cnt = 16'd0;
      exp_q.push_back(g);
    end
    push_byte(8'hFB, 1'b1);
    if (under_m > 0 || n >= 10) begin
      int full = (under_m > 0) ? under_m : 8;
      for (int i = 0; i < full; i++)
        for (int j = (i == 0) ? 1 : 0; j < 8; j++) push_byte(words[i][8*j +: 8], 1'b0);
      push_stream();
      push_error(under_m > 0, under_m == 0);
      pending_gap = gap_words(0) + ((under_m > 0) ? 0 : (n - 9));
    end else begin
      for (int i = 0; i < n; i++)
        for (int j = (i == 0) ? 1 : 0; j < ((i == n - 1) ? k : 8); j++)
          push_byte(words[i][8*j +: 8], 1'b0);
      push_byte(8'hFD, 1'b1);
      tail = 0;
      while (sb_q.size() % 8 != 0) begin
        push_byte(8'h07, 1'b1);
        tail++;
      end
      push_stream();
      pending_gap = gap_words(tail);
    end
    for (int i = 0; i < nw; i++) begin
      if (under_m == 0 && i == nw - 1) send_word(words[i], 1'b1, keepm);
      else                             send_word(words[i], 1'b0, 8'($urandom));
    end
    if (under_m > 0) begin
      i_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d tokens outstanding, expected 0", exp_q.size());
    end
  endtask

  // Monitor: collapse idle runs, compare every non-idle word and preceding gap
  initial begin
    int   run   = 0;
    bit   first = 1'b1;
    tok_t t;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        run = 0;
        first = 1'b1;
      end else if (o_txd == IDLEW && o_txc == 8'hFF && !o_underrun && !o_oversize) begin
        run++;
      end else begin
        if (run > 0 && !first) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL gap: got %0d idle words, expected no output", run);
          end else begin
            t = exp_q.pop_front();
            if (!t.is_gap || t.gap_words != run) begin
              errors++;
              $display("FAIL gap: got %0d idle words, expected %0d (gap token %0d)",
                       run, t.gap_words, t.is_gap);
            end
          end
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL word: got txd=%h txc=%h, expected no output", o_txd, o_txc);
        end else begin
          t = exp_q.pop_front();
          if (t.is_gap || t.txd !== o_txd || t.txc !== o_txc || t.ur !== o_underrun ||
              t.ov !== o_oversize || t.cnt !== o_frame_count) begin
            errors++;
            $display("FAIL word: got txd=%h txc=%h ur=%b ov=%b cnt=%0d expected txd=%h txc=%h ur=%b ov=%b cnt=%0d gap_token=%0d",
                     o_txd, o_txc, o_underrun, o_oversize, o_frame_count,
                     t.txd, t.txc, t.ur, t.ov, t.cnt, t.is_gap);
          end
        end
        run = 0;
        first = 1'b0;
      end
    end
  end

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_last = 1'b0; i_keep = 8'h00; i_data = 64'd0;
    #12;
    chk("reset_txd", o_txd, IDLEW);
    chk("reset_txc", {56'd0, o_txc}, 64'hFF);
    chk("reset_flags", {62'd0, o_underrun, o_oversize}, 64'd0);
    chk("reset_count", {48'd0, o_frame_count}, 64'd0);
    @(posedge clk); #1;
    i_rst = 1'b0;
    mon_en = 1'b1;
    #1;
    chk("ready_after_reset", {63'd0, o_ready}, 64'd1);

    send_frame(9, 4, 0);
    send_frame(9, 4, 0);
    send_frame(3, 8, 0);
    send_frame(0, 0, 4);
    send_frame(12, 4, 0);
    send_frame(1, 2, 0);
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 5) == 0) send_frame(0, 0, $urandom_range(1, 8));
      else send_frame($urandom_range(1, 12), $urandom_range(1, 8), 0);
    end
    i_valid = 1'b0; i_last = 1'b0;
    drain();
    chk("frame_count_total", {48'd0, o_frame_count}, {48'd0, 16'(model_count)});

    mon_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send_word({$urandom, $urandom}, 1'b0, 8'hFF);
    send_word({$urandom, $urandom}, 1'b0, 8'hFF);
    i_rst = 1'b1; i_valid = 1'b0;
    #1;
    chk("midrst_txd", o_txd, IDLEW);
    chk("midrst_txc", {56'd0, o_txc}, 64'hFF);
    chk("midrst_count", {48'd0, o_frame_count}, 64'd0);
    chk("midrst_ready", {63'd0, o_ready}, 64'd1);
    @(posedge clk); #1;
    i_rst = 1'b0;
    exp_q.delete(); sb_q.delete(); sc_q.delete();
    model_count = 0; pending_gap = 0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    send_frame(3, 5, 0);
    send_frame(1, 8, 0);
    i_valid = 1'b0; i_last = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
